// File: rtl/mul_hilo_ctrl.sv
// mul_hilo_ctrl: sequencer around a combinational 32x32 Booth multiplier array.
// Latches operands on start, lets the array settle for SETTLE_CYCLES, then
// captures the 64-bit product into HI/LO. Also serves mthi/mtlo writes and
// stalls mfhi/mflo while a multiply is in flight.
// Optional build macro: MUL_ZERO_BYPASS_EN (a zero operand completes at once).
module mul_hilo_ctrl #(
  parameter int          SETTLE_CYCLES = 4,
  parameter logic [31:0] HILO_INIT     = 32'h0
) (
  input  logic        clock,
  input  logic        clear_n,
  input  logic        start,
  input  logic [31:0] multiplicand_in,
  input  logic [31:0] multiplier_in,
  input  logic        abort,
  input  logic        wr_hi,
  input  logic        wr_lo,
  input  logic [31:0] wr_data,
  input  logic        rd_hi,
  input  logic        rd_lo,
  input  logic [63:0] product_in,
  output logic [31:0] mcand_out,
  output logic [31:0] mplier_out,
  output logic [31:0] hi_out,
  output logic [31:0] lo_out,
  output logic        busy,
  output logic        done,
  output logic        stall
);

  localparam int CNT_W = $clog2(SETTLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE_CYCLES - 1);

`ifdef MUL_ZERO_BYPASS_EN
  localparam bit ZERO_BYPASS = 1'b1;
`else
  localparam bit ZERO_BYPASS = 1'b0;
`endif

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [31:0]       mcand_q, mcand_d;
  logic [31:0]       mplier_q, mplier_d;
  logic [31:0]       hi_q, hi_d;
  logic [31:0]       lo_q, lo_d;
  logic              zero_op;

  assign zero_op = (multiplicand_in == 32'h0) || (multiplier_in == 32'h0);

  // Next-state, counter, operand and HI/LO update logic.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    case (state_q)
      // IDLE and DONE accept writes and new operations; DONE with start
      // launches straight into the next op without passing through IDLE.
      IDLE, DONE: begin
        state_d = IDLE;
        if (wr_hi) hi_d = wr_data;
        if (wr_lo) lo_d = wr_data;
        if (start) begin
          mcand_d  = multiplicand_in;
          mplier_d = multiplier_in;
          if (ZERO_BYPASS && zero_op) begin
            hi_d    = 32'h0;
            lo_d    = 32'h0;
            cnt_d   = '0;
            state_d = DONE;
          end else begin
            cnt_d   = CNT_LOAD;
            state_d = WAIT;
          end
        end
      end
      // WAIT ignores start and writes; abort takes priority over capture.
      WAIT: begin
        if (abort) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else if (cnt_q == '0) begin
          hi_d    = product_in[63:32];
          lo_d    = product_in[31:0];
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  // State, counter, operand and HI/LO registers with synchronous active-low clear.
  always_ff @(posedge clock) begin
    if (!clear_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      mcand_q  <= 32'h0;
      mplier_q <= 32'h0;
      hi_q     <= HILO_INIT;
      lo_q     <= HILO_INIT;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
    end
  end

  assign mcand_out  = mcand_q;
  assign mplier_out = mplier_q;
  assign hi_out     = hi_q;
  assign lo_out     = lo_q;
  assign busy       = (state_q == WAIT);
  assign done       = (state_q == DONE);
  assign stall      = busy & (rd_hi | rd_lo);

endmodule
